// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the pipeline controller: state encodings,
// register reset defaults and the per-cycle control word shapes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2,
    ST_RSVD     = 2'd3
  } state_e;

  // dff_set-style reset defaults
  localparam state_e STATE_RST = ST_RUN;
  localparam logic   FAULT_RST = 1'b0;

  // A flush loads a NOP into the target register; a bubble zeroes MEM/WB.
  typedef struct packed {
    logic hold_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic bubble_mem_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = 7'b000_0000;
  localparam ctrl_t CTRL_MSTALL   = 7'b111_1001;
  localparam ctrl_t CTRL_JUMP     = 7'b000_0110;
  localparam ctrl_t CTRL_LOAD_USE = 7'b110_0010;
  localparam ctrl_t CTRL_CLEAR    = 7'b000_0111;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detect: the load in EX writes a register the ID instruction reads.
module hazard_detect (
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_is_load_i,
  output logic       lu_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
  // x0 is never a real dependency
  assign lu_o    = ex_is_load_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout fault,
// load-use and jump handling, and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             clear_fault_i,
  output logic             hold_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             stall_ex_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             bubble_mem_wb_o,
  output logic [1:0]       state_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu, in_fault, clear_cyc, mstall;
  ctrl_t            ctrl;

  hazard_detect u_hazard (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_is_load_i  (ex_is_load_i),
    .lu_o          (lu)
  );

  assign in_fault  = (state_q == ST_FAULT) || (state_q == ST_RSVD);
  assign clear_cyc = in_fault && clear_fault_i;
  assign mstall    = (mem_req_i && !mem_ready_i) || in_fault;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d = ST_MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        // ready or an aborted request both release the wait
        if (!mem_req_i || mem_ready_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      default: begin
        if (clear_fault_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
          fault_d = 1'b0;
        end
      end
    endcase

    // The clear cycle outranks the fault freeze so stale stages are flushed.
    if (rst)            ctrl = CTRL_IDLE;
    else if (clear_cyc) ctrl = CTRL_CLEAR;
    else if (mstall)    ctrl = CTRL_MSTALL;
    else if (ex_jump_i) ctrl = CTRL_JUMP;
    else if (lu)        ctrl = CTRL_LOAD_USE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_RST;
      wait_q  <= '0;
      fault_q <= FAULT_RST;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (ctrl.hold_pc && (stall_q != '1))     stall_q <= stall_q + CNT_W'(1);
      if (ctrl.flush_if_id && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hold_pc_o       = ctrl.hold_pc;
  assign stall_if_id_o   = ctrl.stall_if_id;
  assign stall_id_ex_o   = ctrl.stall_id_ex;
  assign stall_ex_mem_o  = ctrl.stall_ex_mem;
  assign flush_if_id_o   = ctrl.flush_if_id;
  assign flush_id_ex_o   = ctrl.flush_id_ex;
  assign bubble_mem_wb_o = ctrl.bubble_mem_wb;
  assign state_o         = state_q;
  assign fault_o         = fault_q;
  assign stall_cycles_o  = stall_q;
  assign flush_events_o  = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam int CW = 4;

  // control word order: hold, s_if_id, s_id_ex, s_ex_mem, f_if_id, f_id_ex, bubble
  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_MS   = 7'b111_1001;
  localparam logic [6:0] C_JMP  = 7'b000_0110;
  localparam logic [6:0] C_LU   = 7'b110_0010;
  localparam logic [6:0] C_CLR  = 7'b000_0111;
  localparam logic [1:0] RUN = 2'd0, MW = 2'd1, FLT = 2'd2;

  typedef struct packed {
    logic [6:0]    c;
    logic [1:0]    s;
    logic          f;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, exrd;
  logic u1, u2, ld, jmp, req, rdy, clr;
  logic hold, sif, side, sexm, fif, fide, bub;
  logic [1:0] st;
  logic flt;
  logic [CW-1:0] sc, fe;

  exp_t sbq[$];
  logic [CW-1:0] sc_m, fe_m;
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_addr_i(exrd), .ex_is_load_i(ld), .ex_jump_i(jmp),
    .mem_req_i(req), .mem_ready_i(rdy), .clear_fault_i(clr),
    .hold_pc_o(hold), .stall_if_id_o(sif), .stall_id_ex_o(side),
    .stall_ex_mem_o(sexm), .flush_if_id_o(fif), .flush_id_ex_o(fide),
    .bubble_mem_wb_o(bub), .state_o(st), .fault_o(flt),
    .stall_cycles_o(sc), .flush_events_o(fe)
  );

  // monitor
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {hold, sif, side, sexm, fif, fide, bub};
      ntests++;
      if (a !== e.c) begin
        nfail++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, a, e.c);
      end
      ntests++;
      if ({st, flt} !== {e.s, e.f}) begin
        nfail++;
        $display("FAIL state/fault t=%0t got=%0d/%b want=%0d/%b", $time, st, flt, e.s, e.f);
      end
      ntests++;
      if ({sc, fe} !== {e.sc, e.fe}) begin
        nfail++;
        $display("FAIL counters t=%0t got=%0d/%0d want=%0d/%0d", $time, sc, fe, e.sc, e.fe);
      end
    end
  end

  task automatic clr_in();
    rs1 = 0; rs2 = 0; exrd = 0; u1 = 0; u2 = 0; ld = 0;
    jmp = 0; req = 0; rdy = 0; clr = 0;
  endtask

  // inputs are already applied; queue this cycle's expectation, then advance
  task automatic cyc(input logic [6:0] c, input logic [1:0] s, input logic f);
    exp_t e;
    e.c = c; e.s = s; e.f = f; e.sc = sc_m; e.fe = fe_m;
    sbq.push_back(e);
    if (c[6] && sc_m != '1) sc_m = sc_m + 1'b1;
    if (c[2] && fe_m != '1) fe_m = fe_m + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] a1, input logic use1,
                        input logic [4:0] a2, input logic use2, input logic isld);
    exrd = rd; rs1 = a1; u1 = use1; rs2 = a2; u2 = use2; ld = isld;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr_in(); sc_m = 0; fe_m = 0;
    @(posedge clk); #1;
    // reset holds everything quiet even with hazards presented
    jmp = 1; req = 1; set_lu(5, 5, 1, 0, 0, 1);
    cyc(C_NONE, RUN, 0);
    rst = 1'b0; clr_in();
    cyc(C_NONE, RUN, 0);

    // load-use on rs1, one bubble only
    set_lu(5, 5, 1, 0, 0, 1);  cyc(C_LU, RUN, 0);
    clr_in();                  cyc(C_NONE, RUN, 0);
    set_lu(7, 0, 0, 7, 1, 1);  cyc(C_LU, RUN, 0);
    set_lu(9, 9, 0, 3, 1, 1);  cyc(C_NONE, RUN, 0);
    set_lu(9, 9, 1, 0, 0, 0);  cyc(C_NONE, RUN, 0);
    set_lu(0, 0, 1, 0, 1, 1);  cyc(C_NONE, RUN, 0);
    // jump outranks load-use
    set_lu(5, 5, 1, 0, 0, 1); jmp = 1; cyc(C_JMP, RUN, 0);
    clr_in();                  cyc(C_NONE, RUN, 0);

    // three-cycle memory wait then ready
    req = 1; rdy = 0;
    cyc(C_MS, RUN, 0); cyc(C_MS, MW, 0); cyc(C_MS, MW, 0);
    rdy = 1;                   cyc(C_NONE, MW, 0);
    clr_in();                  cyc(C_NONE, RUN, 0);

    // jump held through the wait is honoured on release
    req = 1; jmp = 1;
    cyc(C_MS, RUN, 0); cyc(C_MS, MW, 0);
    rdy = 1;                   cyc(C_JMP, MW, 0);
    clr_in();                  cyc(C_NONE, RUN, 0);

    // aborted access
    req = 1;                   cyc(C_MS, RUN, 0);
    req = 0;                   cyc(C_NONE, MW, 0);
    cyc(C_NONE, RUN, 0);

    // timeout into fault, then clear
    req = 1;
    cyc(C_MS, RUN, 0); cyc(C_MS, MW, 0); cyc(C_MS, MW, 0); cyc(C_MS, MW, 0);
    req = 0; jmp = 1;          cyc(C_MS, FLT, 1);
    jmp = 0;                   cyc(C_MS, FLT, 1);
    clr = 1;                   cyc(C_CLR, FLT, 1);
    clr_in();                  cyc(C_NONE, RUN, 0);

    // reset mid-wait clears everything at once, no flush afterwards
    req = 1; jmp = 1;
    cyc(C_MS, RUN, 0); cyc(C_MS, MW, 0);
    rst = 1'b1; sc_m = 0; fe_m = 0;
    cyc(C_NONE, RUN, 0);
    rst = 1'b0; clr_in();      cyc(C_NONE, RUN, 0);

    // stall counter saturation
    set_lu(3, 3, 1, 0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(C_LU, RUN, 0);
    clr_in();                  cyc(C_NONE, RUN, 0);

    @(negedge clk);
    ntests++;
    if (sbq.size() != 0) begin
      nfail++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
